// File: rtl/sram_arbiter.sv
// Multi-client arbiter for the asynchronous SRAM. Each grant becomes one read or
// write whose strobes are held for WAIT_CYCLES, followed by a one-cycle ack/rvalid.
module sram_arbiter #(
  parameter int CLIENTS     = 2,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter int FIXED_PRIO  = 0,
  localparam int BE_W       = DATA_W / 8
) (
  input  logic                     clk100,
  input  logic                     reset,
  input  logic [CLIENTS-1:0]        req,
  input  logic [CLIENTS-1:0]        wr,
  input  logic [CLIENTS*ADDR_W-1:0] addr,
  input  logic [CLIENTS*DATA_W-1:0] wdata,
  input  logic [CLIENTS*BE_W-1:0]   be,
  output logic [CLIENTS-1:0]        ack,
  output logic [CLIENTS-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         ram_addr,
  output logic [DATA_W-1:0]         ram_dout,
  input  logic [DATA_W-1:0]         ram_din,
  output logic                      ram_ce,
  output logic                      ram_oe,
  output logic                      ram_we,
  output logic [BE_W-1:0]           ram_be
);

  localparam int IDX_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(CLIENTS - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   grant_q, last_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  dout_q;
  logic [BE_W-1:0]    be_q;
  logic [DATA_W-1:0]  rdata_q;
  logic [CLIENTS-1:0] ack_q, ack_d;
  logic [CLIENTS-1:0] rvalid_q, rvalid_d;
  logic               ce_q, ce_d;
  logic               oe_q, oe_d;
  logic               we_q, we_d;

  logic [IDX_W-1:0]   pick;
  logic               anyReq;
  logic               found;
  logic               wrNext;
  int                 idx;

  assign anyReq = |req;

  // Round-robin searches upward from the client after last_q; fixed priority takes the lowest index
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    if (FIXED_PRIO != 0) begin
      for (int i = CLIENTS - 1; i >= 0; i--) begin
        if (req[i]) pick = IDX_W'(i);
      end
    end else begin
      for (int k = 1; k <= CLIENTS; k++) begin
        idx = int'(last_q) + k;
        if (idx >= CLIENTS) idx = idx - CLIENTS;
        if (!found && req[idx]) begin
          pick  = IDX_W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (anyReq) state_d = ACCESS;
      ACCESS:  if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and ack are decoded from the next state so that they leave flops directly
  always_comb begin
    wrNext = (state_q == IDLE) ? wr[pick] : wr_q;
    ce_d   = (state_d == ACCESS);
    oe_d   = ce_d & ~wrNext;
    we_d   = ce_d & wrNext;
    ack_d  = '0;
    if (state_d == DONE) begin
      for (int i = 0; i < CLIENTS; i++) ack_d[i] = (grant_q == IDX_W'(i));
    end
    rvalid_d = ack_d & {CLIENTS{~wr_q}};
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      cnt_q    <= '0;
      grant_q  <= '0;
      last_q   <= LAST_RST;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      dout_q   <= '0;
      be_q     <= '0;
      rdata_q  <= '0;
      ack_q    <= '0;
      rvalid_q <= '0;
      ce_q     <= 1'b0;
      oe_q     <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && anyReq) begin
        grant_q <= pick;
        last_q  <= pick;
        wr_q    <= wr[pick];
        addr_q  <= addr[pick*ADDR_W +: ADDR_W];
        dout_q  <= wdata[pick*DATA_W +: DATA_W];
        be_q    <= be[pick*BE_W +: BE_W];
        cnt_q   <= CNT_LOAD;
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // Pads are sampled only at the end of the final strobe cycle
      if (state_q == ACCESS && cnt_q == '0 && !wr_q) rdata_q <= ram_din;
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      ce_q     <= ce_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
    end
  end

  assign ack      = ack_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign ram_addr = addr_q;
  assign ram_dout = dout_q;
  assign ram_be   = be_q;
  assign ram_ce   = ce_q;
  assign ram_oe   = oe_q;
  assign ram_we   = we_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: dutA is round-robin with one wait cycle, dutB is fixed
// priority with three; both are compared every cycle against a transaction model.
module tb_sram_arbiter;

  logic        clk;
  logic        rst     [2];
  logic [1:0]  req     [2];
  logic [1:0]  wr      [2];
  logic [35:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [3:0]  be      [2];
  logic [1:0]  ack     [2];
  logic [1:0]  rvalid  [2];
  logic [15:0] rdata   [2];
  logic [17:0] ramAddr [2];
  logic [15:0] ramDout [2];
  logic [15:0] ramDin  [2];
  logic        ce      [2];
  logic        oe      [2];
  logic        we      [2];
  logic [1:0]  ramBe   [2];

  logic [15:0] memA [logic [17:0]];
  logic [15:0] memB [logic [17:0]];
  logic        ovOn  [2];
  logic [15:0] ovVal [2];

  int checks = 0;
  int errors = 0;
  bit checkOn = 0;

  // Model: an access is a grant followed by a phase count; phases 1..W strobe, W+1 acks
  bit          mActive [2];
  int          mPhase  [2];
  int          mG      [2];
  int          mLast   [2];
  logic        mWr     [2];
  logic [17:0] mAddr   [2];
  logic [15:0] mDout   [2];
  logic [15:0] mRdata  [2];
  logic [1:0]  mBe     [2];

  sram_arbiter #(.CLIENTS(2), .ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1), .FIXED_PRIO(0)) dutA (
    .clk100(clk), .reset(rst[0]), .req(req[0]), .wr(wr[0]), .addr(addr[0]), .wdata(wdata[0]),
    .be(be[0]), .ack(ack[0]), .rvalid(rvalid[0]), .rdata(rdata[0]), .ram_addr(ramAddr[0]),
    .ram_dout(ramDout[0]), .ram_din(ramDin[0]), .ram_ce(ce[0]), .ram_oe(oe[0]), .ram_we(we[0]),
    .ram_be(ramBe[0]));

  sram_arbiter #(.CLIENTS(2), .ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(3), .FIXED_PRIO(1)) dutB (
    .clk100(clk), .reset(rst[1]), .req(req[1]), .wr(wr[1]), .addr(addr[1]), .wdata(wdata[1]),
    .be(be[1]), .ack(ack[1]), .rvalid(rvalid[1]), .rdata(rdata[1]), .ram_addr(ramAddr[1]),
    .ram_dout(ramDout[1]), .ram_din(ramDin[1]), .ram_ce(ce[1]), .ram_oe(oe[1]), .ram_we(we[1]),
    .ram_be(ramBe[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int waitOf(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] memRead(input int i, input logic [17:0] a);
    if (i == 0 && memA.exists(a)) return memA[a];
    if (i == 1 && memB.exists(a)) return memB[a];
    if (a == 18'h00123) return 16'hBEEF;
    if (a == 18'h3FFFF) return 16'h5678;
    return 16'h0000;
  endfunction

  // SRAM model: byte-masked writes while WE is high, pads follow the address unless overridden
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (ce[i] && we[i]) begin
        logic [15:0] old;
        logic [15:0] nw;
        old = memRead(i, ramAddr[i]);
        nw[15:8] = ramBe[i][1] ? ramDout[i][15:8] : old[15:8];
        nw[7:0]  = ramBe[i][0] ? ramDout[i][7:0]  : old[7:0];
        if (i == 0) memA[ramAddr[i]] = nw;
        else        memB[ramAddr[i]] = nw;
      end
      ramDin[i] = ovOn[i] ? ovVal[i] : memRead(i, ramAddr[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int g;
      if (rst[i]) begin
        mActive[i] = 1'b0;
        mPhase[i]  = 0;
        mG[i]      = 0;
        mLast[i]   = 1;
        mWr[i]     = 1'b0;
        mAddr[i]   = '0;
        mDout[i]   = '0;
        mRdata[i]  = '0;
        mBe[i]     = '0;
      end else if (mActive[i]) begin
        if (mPhase[i] == waitOf(i) && !mWr[i]) mRdata[i] = ramDin[i];
        if (mPhase[i] == waitOf(i) + 1) begin
          mActive[i] = 1'b0;
          mPhase[i]  = 0;
        end else begin
          mPhase[i] = mPhase[i] + 1;
        end
      end else if (req[i] != 2'b00) begin
        if (i == 1) begin
          g = req[i][0] ? 0 : 1;
        end else begin
          g = (mLast[i] + 1) % 2;
          if (!req[i][g]) g = (g + 1) % 2;
        end
        mG[i]      = g;
        mLast[i]   = g;
        mWr[i]     = wr[i][g];
        mAddr[i]   = addr[i][g*18 +: 18];
        mDout[i]   = wdata[i][g*16 +: 16];
        mBe[i]     = be[i][g*2 +: 2];
        mActive[i] = 1'b1;
        mPhase[i]  = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      for (int i = 0; i < 2; i++) begin
        logic       eCe;
        logic [1:0] eAck;
        eCe  = mActive[i] && (mPhase[i] <= waitOf(i));
        eAck = (mActive[i] && mPhase[i] == waitOf(i) + 1) ? (2'b01 << mG[i]) : 2'b00;
        checkOutput($sformatf("dut%0d.ram_ce", i), ce[i], eCe);
        checkOutput($sformatf("dut%0d.ram_oe", i), oe[i], eCe & ~mWr[i]);
        checkOutput($sformatf("dut%0d.ram_we", i), we[i], eCe & mWr[i]);
        checkOutput($sformatf("dut%0d.ack", i), ack[i], eAck);
        checkOutput($sformatf("dut%0d.rvalid", i), rvalid[i], mWr[i] ? 2'b00 : eAck);
        checkOutput($sformatf("dut%0d.rdata", i), rdata[i], mRdata[i]);
        checkOutput($sformatf("dut%0d.ram_addr", i), ramAddr[i], mAddr[i]);
        checkOutput($sformatf("dut%0d.ram_dout", i), ramDout[i], mDout[i]);
        checkOutput($sformatf("dut%0d.ram_be", i), ramBe[i], mBe[i]);
      end
    end
  end

  task automatic applyStimulus(input int i, input logic [1:0] r, input logic [1:0] w,
                               input logic [35:0] a, input logic [31:0] d, input logic [3:0] b);
    req[i]   = r;
    wr[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    be[i]    = b;
  endtask

  task automatic waitAck(input int i, input int c, input int budget, input string name);
    bit got;
    int n;
    got = 1'b0;
    n   = 0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (ack[i][c]) got = 1'b1;
    end
    checkOutput(name, {31'b0, got}, 32'd1);
  endtask

  initial begin
    int seq[$];
    int times[$];
    int n0;
    int n1;
    for (int i = 0; i < 2; i++) begin
      rst[i]   = 1'b1;
      ovOn[i]  = 1'b0;
      ovVal[i] = 16'h0;
      applyStimulus(i, 2'b00, 2'b00, 36'h0, 32'h0, 4'h0);
    end
    @(negedge clk);
    checkOn = 1'b1;
    checkOutput("resetAck", ack[0], 2'b00);
    checkOutput("resetCe", ce[0], 1'b0);
    checkOutput("resetRdata", rdata[0], 16'h0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Single read, client 0
    applyStimulus(0, 2'b01, 2'b00, {18'h0, 18'h00123}, 32'h0, 4'b0011);
    @(negedge clk);
    checkOutput("readCe", ce[0], 1'b1);
    checkOutput("readOe", oe[0], 1'b1);
    checkOutput("readWe", we[0], 1'b0);
    checkOutput("readAddr", ramAddr[0], 18'h00123);
    @(negedge clk);
    checkOutput("readAck", ack[0], 2'b01);
    checkOutput("readRvalid", rvalid[0], 2'b01);
    checkOutput("readData", rdata[0], 16'hBEEF);
    checkOutput("readCeOff", ce[0], 1'b0);
    applyStimulus(0, 2'b00, 2'b00, 36'h0, 32'h0, 4'h0);
    @(negedge clk);

    // Single write, client 1, high byte only
    applyStimulus(0, 2'b10, 2'b10, {18'h3FFFF, 18'h0}, {16'h1234, 16'h0}, 4'b1000);
    @(negedge clk);
    checkOutput("writeWe", we[0], 1'b1);
    checkOutput("writeOe", oe[0], 1'b0);
    checkOutput("writeBe", ramBe[0], 2'b10);
    checkOutput("writeDout", ramDout[0], 16'h1234);
    @(negedge clk);
    checkOutput("writeAck", ack[0], 2'b10);
    checkOutput("writeRvalid", rvalid[0], 2'b00);
    checkOutput("writeAddrHold", ramAddr[0], 18'h3FFFF);
    checkOutput("writeDoutHold", ramDout[0], 16'h1234);
    checkOutput("writeRdataKept", rdata[0], 16'hBEEF);
    applyStimulus(0, 2'b00, 2'b00, 36'h0, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("writeAddrIdle", ramAddr[0], 18'h3FFFF);
    checkOutput("writeMem", memRead(0, 18'h3FFFF), 16'h1278);

    // Round-robin contention right after reset
    rst[0] = 1'b1;
    @(negedge clk);
    checkOutput("rstAddr", ramAddr[0], 18'h0);
    checkOutput("rstDout", ramDout[0], 16'h0);
    checkOutput("rstBe", ramBe[0], 2'b00);
    checkOutput("rstRdata", rdata[0], 16'h0);
    rst[0] = 1'b0;
    applyStimulus(0, 2'b11, 2'b00, {18'h00002, 18'h00001}, 32'h0, 4'b1111);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (ack[0] != 2'b00) begin
        seq.push_back(ack[0][1] ? 1 : 0);
        times.push_back(c);
      end
    end
    applyStimulus(0, 2'b00, 2'b00, 36'h0, 32'h0, 4'h0);
    checkOutput("rrAckCount", seq.size(), 4);
    for (int k = 0; k < seq.size() && k < 4; k++) begin
      checkOutput($sformatf("rrGrant%0d", k), seq[k], k % 2);
      checkOutput($sformatf("rrTime%0d", k), times[k], 2 + 3 * k);
    end
    @(negedge clk);

    // Reset in the middle of an access drops it; the held request is re-granted
    applyStimulus(0, 2'b01, 2'b00, {18'h0, 18'h00123}, 32'h0, 4'b0011);
    @(negedge clk);
    checkOutput("midCe", ce[0], 1'b1);
    rst[0] = 1'b1;
    @(negedge clk);
    checkOutput("midCeDrop", ce[0], 1'b0);
    checkOutput("midNoAck", ack[0], 2'b00);
    rst[0] = 1'b0;
    @(negedge clk);
    checkOutput("midRegrantCe", ce[0], 1'b1);
    checkOutput("midRegrantAddr", ramAddr[0], 18'h00123);
    waitAck(0, 0, 2, "midRegrantAck");
    applyStimulus(0, 2'b00, 2'b00, 36'h0, 32'h0, 4'h0);

    // Fixed priority on dutB: client 0 starves client 1 until it drops
    applyStimulus(1, 2'b11, 2'b00, {18'h00011, 18'h00010}, 32'h0, 4'b1111);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ack[1][1]) n1++;
      if (ack[1][0]) begin
        n0++;
        if (n0 == 2) begin
          req[1][0] = 1'b0;
          break;
        end
      end
    end
    checkOutput("fpClient0Acks", n0, 2);
    checkOutput("fpClient1Starved", n1, 0);
    waitAck(1, 1, 5, "fpClient1Ack");
    applyStimulus(1, 2'b00, 2'b00, 36'h0, 32'h0, 4'h0);
    @(negedge clk);

    // Wait states: only the pad value in the last strobe cycle is captured
    applyStimulus(1, 2'b10, 2'b00, {18'h00200, 18'h0}, 32'h0, 4'b1111);
    @(negedge clk);
    checkOutput("wsCe1", ce[1], 1'b1);
    ovOn[1]  = 1'b1;
    ovVal[1] = 16'h1111;
    @(negedge clk);
    checkOutput("wsCe2", ce[1], 1'b1);
    ovVal[1] = 16'h2222;
    @(negedge clk);
    checkOutput("wsCe3", ce[1], 1'b1);
    checkOutput("wsOe3", oe[1], 1'b1);
    ovVal[1] = 16'h3333;
    @(negedge clk);
    checkOutput("wsCeOff", ce[1], 1'b0);
    checkOutput("wsAck", ack[1], 2'b10);
    checkOutput("wsRvalid", rvalid[1], 2'b10);
    checkOutput("wsRdata", rdata[1], 16'h3333);
    applyStimulus(1, 2'b00, 2'b00, 36'h0, 32'h0, 4'h0);
    ovOn[1] = 1'b0;
    repeat (2) @(negedge clk);

    checkOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
